// File: rtl/max11643_pkg.sv
// Shared constants, FSM state encodings and helpers for the MAX11643 scan scheduler.
package max11643_pkg;

    localparam int unsigned NUM_CH_DEFAULT  = 9;
    localparam int unsigned TIMEOUT_DEFAULT = 4096;
    localparam int unsigned PERIOD_W_DEFAULT = 16;

    localparam int unsigned StateW = 3;

    localparam logic [StateW-1:0] StIdle  = 3'd0;
    localparam logic [StateW-1:0] StArm   = 3'd1;
    localparam logic [StateW-1:0] StScan  = 3'd2;
    localparam logic [StateW-1:0] StDrain = 3'd3;
    localparam logic [StateW-1:0] StWait  = 3'd4;

    // Index of the lowest set bit; 0 when no bit is set (callers gate on |v).
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/max11643_result_bank.sv
// Per-channel 8-bit sample registers with a registered read port and captured flags.
module max11643_result_bank
    import max11643_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEFAULT
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              clr_valid_i,
    input  logic              wr_en_i,
    input  logic [3:0]        wr_ch_i,
    input  logic [7:0]        wr_data_i,
    input  logic              rd_en_i,
    input  logic [3:0]        rd_ch_i,
    output logic [7:0]        rd_data_o,
    output logic              rd_valid_o,
    output logic [NUM_CH-1:0] ch_valid_o
);

    logic [7:0]        bank_q [NUM_CH];
    logic [7:0]        bank_d [NUM_CH];
    logic [NUM_CH-1:0] ch_valid_q, ch_valid_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic wr_hit;
    logic rd_hit;

    assign wr_hit = wr_en_i && (32'(wr_ch_i) < NUM_CH);
    assign rd_hit = 32'(rd_ch_i) < NUM_CH;

    always_comb begin
        bank_d     = bank_q;
        ch_valid_d = ch_valid_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en_i;
        if (clr_valid_i) begin
            ch_valid_d = '0;
        end
        if (wr_hit) begin
            bank_d[wr_ch_i]     = wr_data_i;
            ch_valid_d[wr_ch_i] = 1'b1;
        end
        // Reads see the pre-write contents, so a same-cycle capture returns old data.
        if (rd_en_i) begin
            rd_data_d = rd_hit ? bank_q[rd_ch_i] : 8'h00;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                bank_q[i] <= '0;
            end
            ch_valid_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            ch_valid_q <= ch_valid_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign ch_valid_o = ch_valid_q;

endmodule

// File: rtl/max11643_scan_scheduler.sv
// Scan FSM, conversion watchdog and period timer for the MAX11643 interface.
// Optional per-channel threshold alarms when MAX11643_SCAN_ALARM_EN is defined.
module max11643_scan_scheduler
    import max11643_pkg::*;
#(
    parameter int unsigned NUM_CH         = NUM_CH_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int unsigned PERIOD_W       = PERIOD_W_DEFAULT
) (
    input  logic                ref_clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stop,
    input  logic                continuous,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic [PERIOD_W-1:0] scan_period,
    output logic                adc_en,
    input  logic [NUM_CH-1:0]   adc_rdy,
    input  logic [7:0]          adc_data,
    output logic                busy,
    output logic                scan_done,
    output logic                timeout_err,
    input  logic                err_clr,
    input  logic                rd_en,
    input  logic [3:0]          rd_ch,
    output logic [7:0]          rd_data,
    output logic                rd_valid,
    output logic [NUM_CH-1:0]   ch_valid
`ifdef MAX11643_SCAN_ALARM_EN
    ,
    input  logic [7:0]          alarm_thresh,
    input  logic                alarm_clr,
    output logic [NUM_CH-1:0]   alarm
`endif
);

    localparam int unsigned WdW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    logic [StateW-1:0]   state_q, state_d;
    logic                adc_en_q, adc_en_d;
    logic                scan_done_q, scan_done_d;
    logic                timeout_err_q, timeout_err_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [WdW-1:0]      wdog_q, wdog_d;
    logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
    logic                abort_q, abort_d;

    logic                strobe;
    logic [3:0]          cap_idx;
    logic [NUM_CH-1:0]   cap_onehot;
    logic [NUM_CH-1:0]   pending_left;
    logic [PERIOD_W-1:0] period_m1;
    logic                wr_en;
    logic                clr_valid;
    logic                timeout_set;

    assign strobe       = |adc_rdy;
    assign cap_idx      = lowest_set(16'(adc_rdy));
    assign cap_onehot   = NUM_CH'(1) << cap_idx;
    assign pending_left = pending_q & ~cap_onehot;
    assign period_m1    = (scan_period == '0) ? '0 : scan_period - PERIOD_W'(1);

    always_comb begin
        state_d     = state_q;
        adc_en_d    = adc_en_q;
        scan_done_d = 1'b0;
        mask_d      = mask_q;
        pending_d   = pending_q;
        wdog_d      = wdog_q;
        per_cnt_d   = per_cnt_q;
        abort_d     = abort_q;
        wr_en       = 1'b0;
        clr_valid   = 1'b0;
        timeout_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                // stop wins over a same-cycle start.
                if (start && !stop && (ch_mask != '0)) begin
                    state_d   = StArm;
                    adc_en_d  = 1'b1;
                    mask_d    = ch_mask;
                    pending_d = ch_mask;
                    wdog_d    = '0;
                    abort_d   = 1'b0;
                    clr_valid = 1'b1;
                end
            end
            StArm, StScan: begin
                if (stop) begin
                    state_d  = StDrain;
                    adc_en_d = 1'b0;
                    abort_d  = 1'b1;
                    wdog_d   = '0;
                end else if (strobe) begin
                    wr_en     = 1'b1;
                    wdog_d    = '0;
                    pending_d = pending_left;
                    if (pending_left == '0) begin
                        state_d     = StDrain;
                        adc_en_d    = 1'b0;
                        scan_done_d = 1'b1;
                        per_cnt_d   = period_m1;
                    end else begin
                        state_d = StScan;
                    end
                end else if (wdog_q == WdLast) begin
                    timeout_set = 1'b1;
                end else begin
                    wdog_d  = wdog_q + WdW'(1);
                    state_d = StScan;
                end
            end
            StDrain: begin
                // The period runs from scan_done, so it keeps counting while draining.
                if (per_cnt_q != '0) begin
                    per_cnt_d = per_cnt_q - PERIOD_W'(1);
                end
                if (stop) begin
                    abort_d = 1'b1;
                end
                if (strobe) begin
                    wdog_d  = '0;
                    state_d = (continuous && !abort_q && !stop) ? StWait : StIdle;
                end else if (wdog_q == WdLast) begin
                    timeout_set = 1'b1;
                end else begin
                    wdog_d = wdog_q + WdW'(1);
                end
            end
            StWait: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (per_cnt_q == '0) begin
                    state_d   = StArm;
                    adc_en_d  = 1'b1;
                    pending_d = mask_q;
                    wdog_d    = '0;
                end else begin
                    per_cnt_d = per_cnt_q - PERIOD_W'(1);
                end
            end
            default: begin
                state_d  = StIdle;
                adc_en_d = 1'b0;
            end
        endcase

        if (timeout_set) begin
            state_d  = StIdle;
            adc_en_d = 1'b0;
            wdog_d   = '0;
        end

        timeout_err_d = timeout_set | (timeout_err_q & ~err_clr);
    end

    always_ff @(posedge ref_clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            adc_en_q      <= 1'b0;
            scan_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            mask_q        <= '0;
            pending_q     <= '0;
            wdog_q        <= '0;
            per_cnt_q     <= '0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            adc_en_q      <= adc_en_d;
            scan_done_q   <= scan_done_d;
            timeout_err_q <= timeout_err_d;
            mask_q        <= mask_d;
            pending_q     <= pending_d;
            wdog_q        <= wdog_d;
            per_cnt_q     <= per_cnt_d;
            abort_q       <= abort_d;
        end
    end

    assign adc_en      = adc_en_q;
    assign busy        = (state_q != StIdle);
    assign scan_done   = scan_done_q;
    assign timeout_err = timeout_err_q;

    max11643_result_bank #(
        .NUM_CH (NUM_CH)
    ) u_bank (
        .clk_i       (ref_clk),
        .reset_ni    (reset_n),
        .clr_valid_i (clr_valid),
        .wr_en_i     (wr_en),
        .wr_ch_i     (cap_idx),
        .wr_data_i   (adc_data),
        .rd_en_i     (rd_en),
        .rd_ch_i     (rd_ch),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .ch_valid_o  (ch_valid)
    );

`ifdef MAX11643_SCAN_ALARM_EN
    logic [NUM_CH-1:0] alarm_q, alarm_d;

    always_comb begin
        alarm_d = alarm_clr ? '0 : alarm_q;
        if (wr_en && (adc_data > alarm_thresh)) begin
            alarm_d = alarm_d | cap_onehot;
        end
    end

    always_ff @(posedge ref_clk) begin
        if (!reset_n) begin
            alarm_q <= '0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`endif

endmodule
